// File: rtl/uart_rx_fifo.sv
// UART receive front end: 2-flop synchroniser, 16x oversampled deframer, FWFT byte FIFO, sticky flags.
// Default frame is 8N1; define UART_RX_PARITY_EN for 8E1 with a parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | timing to mid start bit; a high sample there is a glitch
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit; push byte or flag a framing error
// BREAK  | line still low after a bad stop bit, wait for it to return high
module uart_rx_fifo #(
  parameter int OVS_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic                        clear_err,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int TW = $clog2(OVS_DIV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t        state;
  logic          rx_m, rx_s, rx_d;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    ovs_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, sample;
  logic          push_req, ferr_set, ovr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, do_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign tick   = (state != IDLE) && (tick_cnt == TICK_LAST);
  // mid-bit: the tick that moves the oversample count from 6 to 7
  assign sample = tick && (ovs_cnt == 4'd6);

`ifdef UART_RX_PARITY_EN
  logic par_bad, perr_set;
  assign perr_set = (state == PARITY) && sample && ((^shreg) ^ rx_s);
  assign push_req = (state == STOP) && sample && rx_s && !par_bad;
`else
  assign push_req = (state == STOP) && sample && rx_s;
`endif
  assign ferr_set = (state == STOP) && sample && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      ovs_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + TW'(1);
      if (state == IDLE) ovs_cnt <= '0;
      else if (tick)     ovs_cnt <= ovs_cnt + 4'd1;
      case (state)
        IDLE: if (rx_d && !rx_s) begin
          state <= START;
`ifdef UART_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
        end
        START: if (sample) begin
          bit_idx <= '0;
          state   <= rx_s ? IDLE : DATA;
        end
        DATA: if (sample) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (sample) begin
          par_bad <= (^shreg) ^ rx_s;
          state   <= STOP;
        end
`endif
        STOP:    if (sample) state <= rx_s ? IDLE : BREAK;
        BREAK:   if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_valid = (fifo_level != '0);
  assign rx_data  = mem[rd_ptr];
  assign pop      = rx_valid && rx_ready;
  assign full     = (fifo_level == LVL_FULL);
  assign do_push  = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // a set event in the same cycle as clear_err wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr_set | (frame_err & ~clear_err);
      overrun   <= ovr_set  | (overrun   & ~clear_err);
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_set | (parity_err & ~clear_err);
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed serial frames, checked every cycle against a
// queue model of delivered bytes, occupancy and sticky flags, plus literal spot checks.
module tb_uart_rx_fifo;

  localparam int OVS   = 4;
  localparam int DEPTH = 4;
  localparam int BIT   = 16 * OVS;
`ifdef UART_RX_PARITY_EN
  localparam int NB       = 10;   // stop bit index: start, 8 data, parity
  localparam int STOP_LIT = 670;  // 2 + 4*(7 + 16*10)
`else
  localparam int NB       = 9;    // stop bit index: start, 8 data
  localparam int STOP_LIT = 606;  // 2 + 4*(7 + 16*9)
`endif
  localparam int EV_PUSH = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_level;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo #(.OVS_DIV(OVS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .clear_err  (clear_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  data;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_start = 0;
  ev_t         evq[$];
  logic [7:0]  mq[$];
  logic        m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  logic        m_pop, m_push, m_setf, m_seto, m_setp;
  logic [7:0]  m_pb;
  ev_t         m_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: bytes and flag events land on the edge where the stop/parity bit is sampled.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
        evq.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
      end else begin
        m_push = 1'b0; m_setf = 1'b0; m_setp = 1'b0; m_seto = 1'b0; m_pb = 8'h00;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
          m_ev = evq.pop_front();
          if (m_ev.kind == EV_PUSH) begin m_push = 1'b1; m_pb = m_ev.data; end
          else if (m_ev.kind == EV_FERR) m_setf = 1'b1;
          else m_setp = 1'b1;
        end
        m_pop = (mq.size() > 0) && rx_ready;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          if (mq.size() < DEPTH) mq.push_back(m_pb);
          else m_seto = 1'b1;
        end
        m_ferr = m_setf | (m_ferr & ~clear_err);
        m_ovr  = m_seto | (m_ovr  & ~clear_err);
        m_perr = m_setp | (m_perr & ~clear_err);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
`ifdef UART_RX_PARITY_EN
        chk("rst_parity_err", 32'(parity_err), 0);
`endif
      end else begin
        chk("valid", 32'(rx_valid), 32'(mq.size() > 0));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        if (mq.size() > 0) chk("data", 32'(rx_data), 32'(mq[0]));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
      end
    end
  end

  task automatic wait_bit();
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves rx at the stop-bit level, so stop_b=0 starts a break.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_good);
    int unsigned k, stop_at;
    @(posedge clk);
    #1;
    k = cyc + 1;
    last_start = k;
    stop_at = k + 2 + OVS * (7 + 16 * NB);
`ifdef UART_RX_PARITY_EN
    if (!par_good) evq.push_back(ev_t'{k + 2 + OVS * (7 + 16 * 9), EV_PERR, d});
`endif
    if (!stop_b) evq.push_back(ev_t'{stop_at, EV_FERR, d});
    else if (par_good) evq.push_back(ev_t'{stop_at, EV_PUSH, d});
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_bit();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ ~par_good;
    wait_bit();
`endif
    rx = stop_b;
    wait_bit();
  endtask

  task automatic drain(input string tag, input logic [31:0] exp_bytes, input int n);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, 32'(rx_data), 32'(exp_bytes[8*i +: 8]));
    end
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_data", 32'(rx_data), 0);
    chk("lit_rst_valid", 32'(rx_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // rx_ready on an empty FIFO does nothing
    repeat (5) @(posedge clk);
    #1 rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_ready = 1'b0;

    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_cyc(last_start + STOP_LIT - 1);
        @(negedge clk);
        chk("a5_before_push", 32'(rx_valid), 0);
        @(negedge clk);
        chk("a5_valid", 32'(rx_valid), 1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_level", 32'(fifo_level), 1);
      end
    join
    drain("a5_pop", 32'h000000A5, 1);

    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1);
    @(negedge clk);
    chk("full_level", 32'(fifo_level), 4);
    chk("full_overrun", 32'(overrun), 1);
    drain("order", 32'h04030201, 4);
    @(negedge clk);
    chk("drained_valid", 32'(rx_valid), 0);
    pulse_clear();
    chk("ovr_cleared", 32'(overrun), 0);

    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    send_frame(8'h33, 1'b1, 1'b1);
    send_frame(8'h44, 1'b1, 1'b1);
    fork
      send_frame(8'h66, 1'b1, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_cyc(last_start + STOP_LIT - 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_level", 32'(fifo_level), 4);
        chk("pushpop_overrun", 32'(overrun), 0);
      end
    join
    drain("pushpop_order", 32'h66443322, 4);

    @(posedge clk);
    #1 rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("glitch_valid", 32'(rx_valid), 0);
    chk("glitch_frame_err", 32'(frame_err), 0);

    send_frame(8'h00, 1'b0, 1'b1);
    repeat (BIT * 10) @(posedge clk);
    #1 rx = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("break_frame_err", 32'(frame_err), 1);
    chk("break_level", 32'(fifo_level), 0);
    send_frame(8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    chk("after_break_data", 32'(rx_data), 32'h3C);
    chk("after_break_level", 32'(fifo_level), 1);
    pulse_clear();
    chk("ferr_cleared", 32'(frame_err), 0);

    // 0xFF frame cut by reset in the middle of data bit 4
    @(posedge clk);
    #1 rx = 1'b0;
    wait_bit();
    rx = 1'b1;
    repeat (4 * BIT + BIT / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_data", 32'(rx_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 rx_ready = 1'b1;
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_cyc(last_start + STOP_LIT - 1);
        @(negedge clk);
        chk("5a_before_push", 32'(rx_valid), 0);
        @(negedge clk);
        chk("5a_data", 32'(rx_data), 32'h5A);
        chk("5a_level", 32'(fifo_level), 1);
      end
    join
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("5a_popped", 32'(rx_valid), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    @(negedge clk);
    chk("bad_par_err", 32'(parity_err), 1);
    chk("bad_par_level", 32'(fifo_level), 0);
    send_frame(8'h07, 1'b1, 1'b1);
    @(negedge clk);
    chk("good_par_data", 32'(rx_data), 32'h07);
    chk("good_par_err_held", 32'(parity_err), 1);
    pulse_clear();
    chk("perr_cleared", 32'(parity_err), 0);
`endif

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
